// File: rtl/alu_pkg.sv
// Shared ALU op-codes, flag bit positions, op legality check and arbiter FSM states.
// Pure definitions: no latency, no flow control.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ADDU = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1011;

  localparam int FLAG_ZF = 3;
  localparam int FLAG_SF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_OR,
      OP_AND, OP_SUB, OP_SRA, OP_ADDU, OP_SUBU: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the arbiter, the response sink and the shared ALU.
// slave = arbiter side; master = requesters, response consumer and ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_lhs;
  logic [31:0] req0_rhs;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_lhs;
  logic [31:0] req1_rhs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;

  modport slave (
    input  req0_valid, req0_op, req0_lhs, req0_rhs,
    input  req1_valid, req1_op, req1_lhs, req1_rhs,
    input  rsp_ready, alu_res, alu_flags,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err,
    output alu_op, alu_lhs, alu_rhs
  );

  modport master (
    output req0_valid, req0_op, req0_lhs, req0_rhs,
    output req1_valid, req1_op, req1_lhs, req1_rhs,
    output rsp_ready, alu_res, alu_flags,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err,
    input  alu_op, alu_lhs, alu_rhs
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-requester round-robin: combinational grant, last-grant register updated on accept.
// Ties go to the requester not granted last; last grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant_vld,
  output logic o_grant
);
  logic r_last_grant;
  logic w_grant;

  always_comb begin
    w_grant = 1'b0;
    if (i_valid0 && i_valid1)
      w_grant = ~r_last_grant;
    else if (i_valid1)
      w_grant = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_grant <= 1'b1;
    else if (i_accept)
      r_last_grant <= w_grant;
  end

  assign o_grant     = w_grant;
  assign o_grant_vld = i_valid0 | i_valid1;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; response valid EXEC_CYCLES+1 cycles after accept.
// One operation in flight: requests wait (ready low) until the held response is taken by rsp_ready.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  import alu_pkg::*;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_lhs;
  logic [31:0] r_rhs;
  logic        r_id;
  logic [31:0] r_res;
  logic [3:0]  r_flags;
  logic        r_err;

  logic w_grant_vld;
  logic w_grant;
  logic w_idle;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;
  logic w_legal;
  logic w_cnt_zero;
  logic w_drive;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_valid0    (bus.req0_valid),
    .i_valid1    (bus.req1_valid),
    .i_accept    (w_acc),
    .o_grant_vld (w_grant_vld),
    .o_grant     (w_grant)
  );

  // Readies are forced low while reset is held, not just after it releases.
  assign w_idle         = (r_state == IDLE) && !rst;
  assign bus.req0_ready = w_idle && w_grant_vld && !w_grant;
  assign bus.req1_ready = w_idle && w_grant_vld && w_grant;
  assign w_acc0         = bus.req0_valid && bus.req0_ready;
  assign w_acc1         = bus.req1_valid && bus.req1_ready;
  assign w_acc          = w_acc0 || w_acc1;
  assign w_legal        = op_legal(r_op);
  assign w_cnt_zero     = (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc)         w_state_nxt = EXEC;
      EXEC:    if (w_cnt_zero)    w_state_nxt = DONE;
      DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_lhs   <= '0;
      r_rhs   <= '0;
      r_id    <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_op  <= w_acc1 ? bus.req1_op  : bus.req0_op;
      r_lhs <= w_acc1 ? bus.req1_lhs : bus.req0_lhs;
      r_rhs <= w_acc1 ? bus.req1_rhs : bus.req0_rhs;
      r_id  <= w_acc1;
      r_cnt <= 4'(EXEC_CYCLES - 1);
    end else if (r_state == EXEC) begin
      if (w_cnt_zero) begin
        // Illegal ops still spend the full window but never expose ALU output.
        r_res   <= w_legal ? bus.alu_res   : '0;
        r_flags <= w_legal ? bus.alu_flags : '0;
        r_err   <= !w_legal;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign w_drive       = (r_state != IDLE) && w_legal;
  assign bus.alu_op    = w_drive ? r_op  : 4'd0;
  assign bus.alu_lhs   = w_drive ? r_lhs : 32'd0;
  assign bus.alu_rhs   = w_drive ? r_rhs : 32'd0;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_res   = r_res;
  assign bus.rsp_flags = r_flags;
  assign bus.rsp_err   = r_err;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: EXEC_CYCLES, 1, cycles operands are held on the ALU before result capture (1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req0_ready  input / output  1 / 1  requester 0 handshake.
REQ-005 req0_op / req0_lhs / req0_rhs  input  4 / 32 / 32  requester 0 operation and operands.
REQ-006 req1_valid / req1_ready / req1_op / req1_lhs / req1_rhs  same widths  requester 1.
REQ-007 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-008 rsp_id  output  1  requester index owning the response.
REQ-009 rsp_res / rsp_flags / rsp_err  output  32 / 4 / 1  captured result, {ZF,SF,CF,OF}, illegal-op flag.
REQ-010 alu_op / alu_lhs / alu_rhs  output  4 / 32 / 32  drive to shared ALU.
REQ-011 alu_res / alu_flags  input  32 / 4  ALU result and {ZF,SF,CF,OF}.

Function
REQ-012 FSM states IDLE, EXEC, DONE; reset state IDLE.
REQ-013 reqN_ready = (state==IDLE) && grant==N, combinational; at most one ready high per cycle.
REQ-014 Grant: one valid -> that requester; both valid -> requester other than last_grant; last_grant reset value 1 (req0 wins first tie).
REQ-015 Accept (valid&&ready): latch op/lhs/rhs/id, update last_grant, go EXEC, load counter with EXEC_CYCLES-1.
REQ-016 Legal ops: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 1000 sub, 1001 sra, 1010 addu, 1011 subu; all others illegal.
REQ-017 alu_op/lhs/rhs driven from latched registers in EXEC and DONE, stable throughout; all zero in IDLE and for illegal ops.
REQ-018 EXEC: counter decrements each cycle; at counter==0 capture alu_res/alu_flags into rsp_res/rsp_flags, go DONE.
REQ-019 Illegal op: EXEC still lasts EXEC_CYCLES; capture res=0, flags=0, rsp_err=1.
REQ-020 DONE: rsp_valid=1; rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE.
REQ-021 Latency accept-to-rsp_valid = EXEC_CYCLES+1 cycles; min issue interval EXEC_CYCLES+2 cycles.
REQ-022 Request inputs ignored outside IDLE; requester holds valid and payload stable until ready (protocol rule, asserted in bench).
REQ-023 Valid dropped before grant: no accept, no state change.
REQ-024 Flags pass through unmodified; arbiter performs no arithmetic.

Reset
REQ-025 Async rst: state=IDLE, last_grant=1, counter=0, all latched operand/op/id/rsp registers=0, rsp_valid=0, readies=0 while rst high.
REQ-026 rst mid-EXEC or mid-DONE aborts the operation; no response emitted afterwards.
REQ-027 First accept possible on the first rising edge after rst deasserts.

Structure
REQ-028 Shared package alu_pkg: 4-bit op-code constants, flag bit indices (ZF=3,SF=2,CF=1,OF=0), op-legal function, FSM state enum.
REQ-029 One sub-module rr_arbiter2: two-requester round-robin grant with last_grant register.
REQ-030 ALU instantiated outside; arbiter only connects to its ports.

Verification
REQ-031 req0 add lhs=7fffffff rhs=10000003, EXEC_CYCLES=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_res=8fffffff+3=90000002, rsp_flags=alu_flags.
REQ-032 Both valid from reset (req0 sll 000f0000<<2, req1 sub 00000001-00000002) -> req0 served first (res 003c0000), then req1 (res ffffffff), strictly alternating over 4 back-to-back pairs.
REQ-033 req1 op=0101, lhs=1, rhs=1 -> rsp_err=1, rsp_res=0, rsp_flags=0, alu_op/lhs/rhs remain 0.
REQ-034 rsp_ready held low 5 cycles in DONE -> rsp_* unchanged, both readies 0, new request accepted only after release.
REQ-035 rst asserted mid-EXEC (EXEC_CYCLES=4, cycle 2) -> all outputs zero immediately, no rsp_valid thereafter, next tie grants req0.
REQ-036 EXEC_CYCLES=4, req0 sra ffffffff>>3 -> alu_* stable 4 cycles, rsp_res=ffffffff captured on 4th EXEC cycle.
